// File: rtl/line_memory_if.sv
// Request/response handshake between the cache and the line memory responder.
// The shared 64-bit line bus stays a plain inout port on the memory module.
interface line_memory_if;
  logic        readM;
  logic        writeM;
  logic [15:0] address;
  logic        mem_done;
  logic        mem_busy;
  logic        req_conflict;
  logic [15:0] read_count;
  logic [15:0] write_count;

  modport master (
    output readM, writeM, address,
    input  mem_done, mem_busy, req_conflict, read_count, write_count
  );

  modport slave (
    input  readM, writeM, address,
    output mem_done, mem_busy, req_conflict, read_count, write_count
  );
endinterface

// File: rtl/line_memory.sv
// Fixed-latency line memory responder; drives the line bus only during a read response.
// Optional MEM_STATS_EN adds saturating accepted-read/write counters.
module line_memory #(
  parameter int LATENCY        = 3,
  parameter int LINE_ADDR_BITS = 8,
  parameter int LINE_SIZE      = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  line_memory_if.slave         bus_if,
  inout  wire  [LINE_SIZE-1:0] data_between_memory
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH = 2 ** LINE_ADDR_BITS;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [LINE_ADDR_BITS-1:0] line_idx, addr_idx, resp_idx;
  logic [LINE_SIZE-1:0]      wr_data, rd_data, resp_data;
  logic                      op_wr, resp_wr;
  logic                      accept_wr, accept_rd, enter_resp;
  logic                      conflict;
  logic [LINE_SIZE-1:0]      mem [DEPTH];
  logic                      unused_addr_bits;

  assign addr_idx         = bus_if.address[LINE_ADDR_BITS+1:2];
  assign unused_addr_bits = ^{bus_if.address[15:LINE_ADDR_BITS+2], bus_if.address[1:0]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    case (state)
      IDLE: begin
        accept_wr = bus_if.writeM;
        accept_rd = bus_if.readM & ~bus_if.writeM;
        if (accept_wr || accept_rd) begin
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY==1 the response is entered on the accept edge itself, so the
  // commit/fetch takes the request straight from the inputs in that case.
  assign enter_resp = (state_nxt == RESP) && (state != RESP);
  assign resp_wr    = (state == IDLE) ? accept_wr : op_wr;
  assign resp_idx   = (state == IDLE) ? addr_idx : line_idx;
  assign resp_data  = (state == IDLE) ? data_between_memory : wr_data;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_wr    <= 1'b0;
      conflict <= 1'b0;
      line_idx <= '0;
      wr_data  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept_wr || accept_rd) begin
        line_idx <= addr_idx;
        op_wr    <= accept_wr;
        wr_data  <= data_between_memory;
      end
      if (accept_wr && bus_if.readM) conflict <= 1'b1;
    end
  end

  // Array contents survive reset; only an uncommitted write is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n && enter_resp) begin
      if (resp_wr) mem[resp_idx] <= resp_data;
      else         rd_data       <= mem[resp_idx];
    end
  end

  assign data_between_memory = (state == RESP && !op_wr) ? rd_data : 'z;
  assign bus_if.mem_done     = (state == RESP);
  assign bus_if.mem_busy     = (state != IDLE);
  assign bus_if.req_conflict = conflict;

`ifdef MEM_STATS_EN
  logic [15:0] rd_cnt, wr_cnt;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (accept_rd && rd_cnt != '1) rd_cnt <= rd_cnt + 16'd1;
      if (accept_wr && wr_cnt != '1) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  assign bus_if.read_count  = rd_cnt;
  assign bus_if.write_count = wr_cnt;
`else
  assign bus_if.read_count  = '0;
  assign bus_if.write_count = '0;
`endif

endmodule

// File: tb/tb_line_memory.sv
// Scoreboard bench for line_memory: driver predicts responses from a line-array
// model and timing rules; a negedge monitor pops and compares on mem_done.
module tb_line_memory;
  localparam int LATENCY = 3;
  localparam int LAB     = 8;
  localparam int DEPTH   = 2 ** LAB;
`ifdef MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    bit          is_rd;
    int          line;
    logic [63:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tb_drv = 1'b1;
  logic [63:0] tb_pat = '0;
  wire  [63:0] data_between_memory;

  line_memory_if bif ();

  line_memory #(.LATENCY(LATENCY), .LINE_ADDR_BITS(LAB), .LINE_SIZE(64)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .bus_if              (bif),
    .data_between_memory (data_between_memory)
  );

  assign data_between_memory = tb_drv ? tb_pat : 'z;

  always #5 clk = ~clk;

  exp_t        sb[$];
  logic [63:0] mem_model [int];
  int          written_q[$];
  bit          written_map [int];
  int          edge_idx = 0;
  int          next_free = 0;
  int          rel_edge = -10;
  bit          exp_conflict = 1'b0;
  logic [15:0] exp_rd = '0;
  logic [15:0] exp_wr = '0;
  bit          mon_en = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_idx - 1);
    end
  endtask

  // One clock cycle of stimulus plus the reference model's view of that edge.
  task automatic cycle(input bit rst, input bit rd, input bit wr,
                       input logic [15:0] addr, input logic [63:0] pat);
    exp_t e;
    @(negedge clk);
    #1;
    reset_n     = rst;
    bif.readM   = rd;
    bif.writeM  = wr;
    bif.address = addr;
    tb_pat      = pat;
    tb_drv      = !(edge_idx == rel_edge || edge_idx == rel_edge + 1);
    @(posedge clk);
    if (rst) begin
      sb.delete();
      next_free    = edge_idx + 1;
      rel_edge     = -10;
      exp_conflict = 1'b0;
      exp_rd       = '0;
      exp_wr       = '0;
    end else if ((rd || wr) && edge_idx >= next_free) begin
      e.line = (int'(addr) >> 2) % DEPTH;
      e.due  = edge_idx + LATENCY - 1;
      if (wr) begin
        e.is_rd = 1'b0;
        e.data  = pat;
        if (exp_wr != 16'hFFFF) exp_wr = exp_wr + 16'd1;
        if (rd) exp_conflict = 1'b1;
      end else begin
        e.is_rd  = 1'b1;
        e.data   = mem_model[e.line];
        if (exp_rd != 16'hFFFF) exp_rd = exp_rd + 16'd1;
        rel_edge = e.due;
      end
      sb.push_back(e);
      next_free = edge_idx + LATENCY + 1;
    end
    edge_idx++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 16'(($urandom)), {$urandom, $urandom});
  endtask

  function automatic logic [15:0] rd_addr();
    int line;
    line = written_q[$urandom_range(0, written_q.size() - 1)];
    return 16'(($urandom & 32'h0000_FC03) | (line << 2));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("mem_busy", 64'(bif.mem_busy), 64'(sb.size() != 0));
        if (tb_drv) chk("bus_released", data_between_memory, tb_pat);
        if (bif.mem_done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 64'(bif.mem_done), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("resp_timing", 64'(edge_idx - 1), 64'(e.due));
            if (e.is_rd) begin
              chk("read_data", data_between_memory, e.data);
            end else begin
              mem_model[e.line] = e.data;
              if (!written_map.exists(e.line)) begin
                written_map[e.line] = 1'b1;
                written_q.push_back(e.line);
              end
            end
          end
        end else if (sb.size() != 0 && sb[0].due < edge_idx - 1) begin
          e = sb.pop_front();
          chk("missed_done", 64'(bif.mem_done), 64'd1);
        end
        chk("req_conflict", 64'(bif.req_conflict), 64'(exp_conflict));
        chk("read_count",  64'(bif.read_count),  STATS ? 64'(exp_rd) : 64'd0);
        chk("write_count", 64'(bif.write_count), STATS ? 64'(exp_wr) : 64'd0);
      end
    end
  end

  initial begin : driver
    int r;
    bit rd, wr;
    logic [15:0] a;
    bif.readM   = 1'b0;
    bif.writeM  = 1'b0;
    bif.address = '0;
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 64'h0);
    mon_en = 1'b1;
    idle(2);

    // Directed: write line 5, read it back with a different word offset.
    cycle(1'b0, 1'b0, 1'b1, 16'h0014, 64'h4444_3333_2222_1111);
    idle(4);
    cycle(1'b0, 1'b1, 1'b0, 16'h0016, {$urandom, $urandom});
    idle(4);
    // Simultaneous read+write: write wins and the conflict flag sticks.
    cycle(1'b0, 1'b1, 1'b1, 16'h0020, 64'hDEAD_BEEF_0BAD_F00D);
    idle(4);
    cycle(1'b0, 1'b1, 1'b0, 16'h0020, {$urandom, $urandom});
    idle(4);
    // Upper address bits alias onto line 5.
    cycle(1'b0, 1'b0, 1'b1, 16'h0414, 64'hAAAA_BBBB_CCCC_DDDD);
    cycle(1'b0, 1'b1, 1'b0, 16'h0014, {$urandom, $urandom});
    idle(5);
    // Held read level: re-acceptance only after a full idle edge.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0014, {$urandom, $urandom});
    idle(4);

    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      wr = (r <= 2) || (r == 6);
      rd = ((r >= 3 && r <= 6) && written_q.size() != 0);
      a  = (rd && !wr) ? rd_addr() : 16'($urandom);
      cycle(1'b0, rd, wr, a, {$urandom, $urandom});
    end
    idle(5);

    // Reset during WAIT of a write: nothing committed, no response.
    cycle(1'b0, 1'b0, 1'b1, 16'h0014, 64'h0123_4567_89AB_CDEF);
    cycle(1'b1, 1'b0, 1'b0, 16'h0014, {$urandom, $urandom});
    idle(5);
    cycle(1'b0, 1'b1, 1'b0, 16'h0014, {$urandom, $urandom});
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
